fma_issue_ctrl: RTL

//  Operand issue/retire stage upstream of fused_array_mult (A*B+C, 8b exp, 24b mantissa with explicit lead bit).

---
 rtl/fma_pkg.sv | 12 +
 rtl/fp32_unpack.sv | 13 +
 rtl/fma_issue_ctrl.sv | 70 +++++++
 3 files changed

// File: rtl/fma_pkg.sv
// fma_pkg: shared widths, FSM state type and FMA saturation code for the FMA issue stage
package fma_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam int FP_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam logic [EXP_W-1:0] OVF_EXP = 8'h7F;
endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: splits an IEEE single (sign stripped) into exponent and explicit-lead-bit mantissa
module fp32_unpack
  import fma_pkg::*;
#(
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic [FP_W-2:0]  x,
  output logic [EXP_W-1:0] ex,
  output logic [MAN_W-1:0] man
);
  assign ex = x[FP_W-2:MAN_W-1];
  assign man = (ex != '0) ? {1'b1, x[MAN_W-2:0]} : FLUSH_DENORM ? '0 : {1'b0, x[MAN_W-2:0]};
endmodule

// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl: holds unpacked operands for the multicycle FMA path, then captures and repacks the result
module fma_issue_ctrl
  import fma_pkg::*;
#(
  parameter int LAT = 4,
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  op_a,
  input  logic [FP_W-1:0]  op_b,
  input  logic [FP_W-1:0]  op_c,
  output logic [EXP_W-1:0] fma_exp_a,
  output logic [EXP_W-1:0] fma_exp_b,
  output logic [EXP_W-1:0] fma_exp_c,
  output logic [MAN_W-1:0] fma_man_a,
  output logic [MAN_W-1:0] fma_man_b,
  output logic [MAN_W-1:0] fma_man_c,
  input  logic [EXP_W-1:0] fma_exp_ans,
  input  logic [MAN_W-1:0] fma_man_ans,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  result,
  output logic             ovf,
  output logic             sign_err
);
  state_t state, nxt;
  logic [3:0] cnt;
  logic sgn, accept, fire, sat;
  logic [EXP_W-1:0] ea, eb, ec;
  logic [MAN_W-1:0] ma, mb, mc;
  fp32_unpack #(.FLUSH_DENORM(FLUSH_DENORM)) u_a (.x(op_a[FP_W-2:0]), .ex(ea), .man(ma));
  fp32_unpack #(.FLUSH_DENORM(FLUSH_DENORM)) u_b (.x(op_b[FP_W-2:0]), .ex(eb), .man(mb));
  fp32_unpack #(.FLUSH_DENORM(FLUSH_DENORM)) u_c (.x(op_c[FP_W-2:0]), .ex(ec), .man(mc));
  assign in_ready = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign fire = (state == ST_EXEC) && (cnt == '0);
  assign out_valid = (state == ST_DONE);
  assign sat = (fma_exp_ans == OVF_EXP) && (fma_man_ans == '0);
  always_comb begin
    nxt = accept ? ST_EXEC : fire ? ST_DONE : (state == ST_DONE && out_ready) ? ST_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {fma_exp_a, fma_exp_b, fma_exp_c} <= '0;
      {fma_man_a, fma_man_b, fma_man_c} <= '0;
      {sgn, sign_err, ovf, cnt} <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        {fma_exp_a, fma_exp_b, fma_exp_c} <= {ea, eb, ec};
        {fma_man_a, fma_man_b, fma_man_c} <= {ma, mb, mc};
        sgn <= op_a[FP_W-1] ^ op_b[FP_W-1];
        sign_err <= op_a[FP_W-1] ^ op_b[FP_W-1] ^ op_c[FP_W-1];
        cnt <= 4'(LAT - 1);
      end else if (state == ST_EXEC) cnt <= cnt - 4'd1;
      // saturation code from the array maps to a signed infinity
      if (fire) begin
        ovf <= sat;
        result <= sat ? {sgn, 8'hFF, 23'd0} : {sgn, fma_exp_ans, fma_man_ans[MAN_W-2:0]};
      end
    end
  end
endmodule
